// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 9-entry register file: round-robin arbitration
// between two writeback requesters, a clear sweep over addresses 1..NREGS-1,
// and filtering of writes to $0 and out-of-range addresses.
module regfile_write_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int NREGS = 9
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] wd3,
  output logic [AW-1:0] wa3,
  output logic          we3,
  output logic          drop_err
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);
  localparam logic [AW:0]   ADDR_LIM  = (AW + 1)'(NREGS);

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          rr, rr_n;
  logic [DW-1:0] wd3_n;
  logic [AW-1:0] wa3_n;
  logic          we3_n, drop_n, busy_n;

  logic          gnt;
  logic          gsel;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data;
  logic          g_zero, g_illegal;

  // Granted request's payload and address classification.
  always_comb begin
    g_addr    = gsel ? req1_addr : req0_addr;
    g_data    = gsel ? req1_data : req0_data;
    g_zero    = (g_addr == '0);
    g_illegal = ({1'b0, g_addr} >= ADDR_LIM);
  end

  // Next-state, arbitration and next write-port values.
  // The write-port registers are loaded one edge ahead of the state so that
  // the sweep's first write (address 1) is visible in the cycle right after
  // clr_req is taken; in CLEAR the register is therefore loaded with cnt+1.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rr_n       = rr;
    wd3_n      = wd3;
    wa3_n      = wa3;
    we3_n      = 1'b0;
    drop_n     = 1'b0;
    busy_n     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    gnt        = 1'b0;
    gsel       = 1'b0;
    if (!RST) begin
      case (state)
        ARB: begin
          if (clr_req) begin
            state_n = CLEAR;
            cnt_n   = CNT_FIRST;
            we3_n   = 1'b1;
            wa3_n   = CNT_FIRST;
            wd3_n   = '0;
            busy_n  = 1'b1;
          end else begin
            if (req0_valid && req1_valid) begin
              gnt  = 1'b1;
              gsel = rr;
            end else if (req0_valid) begin
              gnt  = 1'b1;
              gsel = 1'b0;
            end else if (req1_valid) begin
              gnt  = 1'b1;
              gsel = 1'b1;
            end
            if (gnt) begin
              req0_ready = ~gsel;
              req1_ready = gsel;
              rr_n       = ~gsel;
              wa3_n      = g_addr;
              wd3_n      = g_data;
              we3_n      = ~g_zero & ~g_illegal;
              drop_n     = g_illegal;
            end
          end
        end
        CLEAR: begin
          if (cnt == CNT_LAST) begin
            state_n = ARB;
            cnt_n   = CNT_FIRST;
          end else begin
            cnt_n  = cnt + AW'(1);
            we3_n  = 1'b1;
            wa3_n  = cnt + AW'(1);
            wd3_n  = '0;
            busy_n = 1'b1;
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

  // State, sweep counter, round-robin pointer and registered write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ARB;
      cnt      <= CNT_FIRST;
      rr       <= 1'b0;
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      drop_err <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rr       <= rr_n;
      we3      <= we3_n;
      wa3      <= wa3_n;
      wd3      <= wd3_n;
      drop_err <= drop_n;
      clr_busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration and
// address filtering, then hand sequences for the clear sweep, reset abort and
// an end-to-end check against a small register-file model.
module tb_regfile_write_arbiter;

  logic       CLK;
  logic       RST;
  logic       clr_req;
  logic       clr_busy;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] wd3;
  logic [3:0] wa3;
  logic       we3;
  logic       drop_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] rf [16];
  logic       rf_init;

  regfile_write_arbiter #(.DW(8), .AW(4), .NREGS(9)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wd3        (wd3),
    .wa3        (wa3),
    .we3        (we3),
    .drop_err   (drop_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register-file model fed by the write port.
  always @(posedge CLK) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'hFF;
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
  end

  typedef struct {
    logic       rst, clr, v0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       v1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       r0, r1;
    logic       chk_out;
    logic       we, drop, busy;
    logic [3:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic clr,
                       input logic v0, input logic [3:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [7:0] d1);
    RST        = rst;
    clr_req    = clr;
    req0_valid = v0;
    req0_addr  = a0;
    req0_data  = d0;
    req1_valid = v1;
    req1_addr  = a1;
    req1_data  = d1;
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic [3:0] wa,
                          input logic [7:0] wd, input logic drop, input logic busy);
    chk({tag, ".we3"}, 32'(we3), 32'(we));
    chk({tag, ".wa3"}, 32'(wa3), 32'(wa));
    chk({tag, ".wd3"}, 32'(wd3), 32'(wd));
    chk({tag, ".drop_err"}, 32'(drop_err), 32'(drop));
    chk({tag, ".clr_busy"}, 32'(clr_busy), 32'(busy));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
  endtask

  initial begin
    rf_init = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

    //                rst   clr   v0    a0    d0     v1    a1    d1     r0    r1    chk   we    drop  busy  wa    wd
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'h3, 8'h5A, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 8'h5A};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 8'h5A};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'h1, 8'h11, 1'b1, 4'h2, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'h1, 8'h11, 1'b1, 4'h2, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 8'h11};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'h1, 8'h11, 1'b1, 4'h2, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 8'h22};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'h1, 8'h11, 1'b1, 4'h2, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 8'h11};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 8'h22};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hC, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h33};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 8'h44};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 8'h44};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h5, 8'h77, 1'b1, 4'h6, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 8'h44};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00};

    // Table: outputs checked are the result of the previous row's inputs.
    for (int i = 0; i < 14; i++) begin
      step();
      if (vecs[i].chk_out)
        chk_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                 vecs[i].drop, vecs[i].busy);
      drive(vecs[i].rst, vecs[i].clr, vecs[i].v0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].a1, vecs[i].d1);
      chk_rdy($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1);
    end

    // Clear pulse while req0 is pending: sweep wins, req0 granted after.
    step();
    drive(1'b0, 1'b1, 1'b1, 4'h4, 8'h66, 1'b0, 4'h0, 8'h00);
    chk_rdy("clr_n", 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_outs($sformatf("clr_n%0d", k), 1'b1, 4'(k), 8'h00, 1'b0, 1'b1);
      clr_req = 1'b0;
      chk_rdy($sformatf("clr_n%0d", k), 1'b0, 1'b0);
    end
    step();
    chk_outs("clr_n9", 1'b0, 4'h8, 8'h00, 1'b0, 1'b0);
    chk_rdy("clr_n9", 1'b1, 1'b0);
    step();
    chk_outs("clr_n10", 1'b1, 4'h4, 8'h66, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

    // Reset during the fourth sweep cycle aborts the sweep and clears rr.
    step();
    drive(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_outs($sformatf("abort_n%0d", k), 1'b1, 4'(k), 8'h00, 1'b0, 1'b1);
      clr_req = 1'b0;
    end
    step();
    chk_outs("abort_n4", 1'b1, 4'h4, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'h6, 8'hA6, 1'b1, 4'h7, 8'hB7);
    chk_rdy("abort_n4", 1'b0, 1'b0);
    step();
    chk_outs("abort_n5", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    chk_rdy("abort_n5", 1'b0, 1'b0);
    step();
    chk_outs("abort_n6", 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
    chk_rdy("abort_n6", 1'b1, 1'b0);
    step();
    chk_outs("abort_n7", 1'b1, 4'h6, 8'hA6, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);

    // End-to-end: $5 written, then wiped by a full sweep.
    step();
    rf_init = 1'b1;
    step();
    rf_init = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 4'h5, 8'h7F, 1'b0, 4'h0, 8'h00);
    chk_rdy("e2e_wr", 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00);
    step();
    chk("e2e_rf5_written", 32'(rf[5]), 32'h7F);
    chk("e2e_rf1_untouched", 32'(rf[1]), 32'hFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 9; k++) step();
    for (int a = 1; a <= 8; a++)
      chk($sformatf("e2e_rf%0d_cleared", a), 32'(rf[a]), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
